// File: rtl/seqdet_pkg.sv
// Shared definitions for the moore101 sequence-detector front end and its bench.
package seqdet_pkg;

    localparam int   DATA_W_DEF     = 20;
    localparam logic IDLE_LEVEL_DEF = 1'b0;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/seqdet_serializer.sv
// Parallel-to-serial front end for moore101: one DATA_W-bit word in, one bit per clk out on x,
// with a single holding register so consecutive words stream without an idle cycle.
module seqdet_serializer
    import seqdet_pkg::*;
#(
    parameter int   DATA_W     = DATA_W_DEF,
    parameter bit   MSB_FIRST  = 1'b0,
    parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              x,
    output logic              x_valid,
    output logic              x_last,
    output logic              busy
);

    localparam int              CW       = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(DATA_W - 1);

    // Handshake: a word transfers on any rising edge where in_valid && in_ready.
    // in_ready is the registered inverse of hold_full, so it never depends on in_valid
    // in the same cycle; while it is low, in_valid and in_data are ignored.

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              x_q, x_d;
    logic              x_valid_q, x_valid_d;
    logic              x_last_q, x_last_d;

    logic              accept;
    logic              load;
    logic [DATA_W-1:0] load_word;
    logic [DATA_W-1:0] shifted;
    logic [CW-1:0]     cnt_inc;

    // The bit on x is always the send-order head of the shifter.
    function automatic logic head_bit(input logic [DATA_W-1:0] d);
        return MSB_FIRST ? d[DATA_W-1] : d[0];
    endfunction

    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] d);
        return MSB_FIRST ? {d[DATA_W-2:0], 1'b0} : {1'b0, d[DATA_W-1:1]};
    endfunction

    assign accept  = in_valid && !hold_full_q;
    assign shifted = advance(shreg_q);
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        x_valid_d   = x_valid_q;
        x_last_d    = x_last_q;
        load        = 1'b0;
        load_word   = in_data;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    load    = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    // Final edge of the word: chain the next word in, or fall idle.
                    if (hold_full_q) begin
                        load        = 1'b1;
                        load_word   = hold_q;
                        hold_full_d = 1'b0;
                    end else if (accept) begin
                        load = 1'b1;
                    end else begin
                        state_d   = S_IDLE;
                        x_d       = IDLE_LEVEL;
                        x_valid_d = 1'b0;
                        x_last_d  = 1'b0;
                    end
                end else begin
                    shreg_d  = shifted;
                    cnt_d    = cnt_inc;
                    x_d      = head_bit(shifted);
                    x_last_d = (cnt_inc == CNT_LAST);
                    if (accept) begin
                        hold_d      = in_data;
                        hold_full_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load) begin
            shreg_d   = load_word;
            cnt_d     = '0;
            x_d       = head_bit(load_word);
            x_valid_d = 1'b1;
            x_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
            x_q         <= IDLE_LEVEL;
            x_valid_q   <= 1'b0;
            x_last_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            x_valid_q   <= x_valid_d;
            x_last_q    <= x_last_d;
        end
    end

    assign in_ready = !hold_full_q;
    assign x        = x_q;
    assign x_valid  = x_valid_q;
    assign x_last   = x_last_q;
    assign busy     = (state_q == S_SHIFT) | hold_full_q;

endmodule

// File: tb/tb_seqdet_serializer.sv
// Directed bench for seqdet_serializer: LSB/MSB order, back-to-back streaming, stall, reset mid-word,
// and a moore101 reference detector chained on x.
module tb_seqdet_serializer;

    localparam int W = 20;
    localparam logic [W-1:0] WORD = 20'b10100101010010101010;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] in_data;
    logic         in_valid;

    logic a_in_ready, a_x, a_x_valid, a_x_last, a_busy;
    logic b_in_ready, b_x, b_x_valid, b_x_last, b_busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [0:0]   exp_q[$];
    logic [W-1:0] words[3];

    int exp_lsb[20] = '{0,1,0,1,0,1,0,1,0,0,1,0,1,0,1,0,0,1,0,1};
    int exp_msb[20] = '{1,0,1,0,0,1,0,1,0,1,0,0,1,0,1,0,1,0,1,0};
    int exp_y[20]   = '{0,0,0,1,0,1,0,1,0,0,0,0,1,0,1,0,0,0,0,1};
    int acc_exp[3]  = '{0,1,21};

    seqdet_serializer #(.DATA_W(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(a_in_ready), .x(a_x), .x_valid(a_x_valid), .x_last(a_x_last), .busy(a_busy)
    );

    seqdet_serializer #(.DATA_W(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_msb (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(b_in_ready), .x(b_x), .x_valid(b_x_valid), .x_last(b_x_last), .busy(b_busy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference moore101: 0 none, 1 seen "1", 2 seen "10", 3 seen "101" (y=1).
    function automatic int moore_next(input int s, input logic xb);
        case (s)
            0:       return xb ? 1 : 0;
            1:       return xb ? 1 : 2;
            2:       return xb ? 3 : 0;
            default: return xb ? 1 : 2;
        endcase
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_x"},        a_x,        0);
        check({tag, "_x_valid"},  a_x_valid,  0);
        check({tag, "_x_last"},   a_x_last,   0);
        check({tag, "_in_ready"}, a_in_ready, 1);
        check({tag, "_busy"},     a_busy,     0);
        check({tag, "_msb_xv"},   b_x_valid,  0);
    endtask

    // Offers nw words from words[], each held on in_valid until accepted; checks the serial stream.
    task automatic run_stream(input int nw, input string tag);
        int idx = 0, nvalid = 0, bitpos = 0, nlast = 0, first_v = -1, last_v = -1;
        int acc_cyc[3];
        int last_cyc[3];
        logic [W-1:0] w;
        exp_q.delete();
        for (int k = 0; k < 3; k++) begin
            acc_cyc[k]  = -1;
            last_cyc[k] = -1;
        end
        for (int c = 0; c < 20 * nw + 4; c++) begin
            if (a_x_valid) begin
                nvalid++;
                if (first_v < 0) first_v = c;
                last_v = c;
                if (exp_q.size() == 0) begin
                    check($sformatf("%s_extra_bit_c%0d", tag, c), 1, 0);
                end else begin
                    check($sformatf("%s_bit_c%0d", tag, c), a_x, exp_q.pop_front());
                end
                check($sformatf("%s_last_c%0d", tag, c), a_x_last, (bitpos == 19));
                if (a_x_last && nlast < 3) begin
                    last_cyc[nlast] = c;
                    nlast++;
                end
                bitpos = (bitpos == 19) ? 0 : bitpos + 1;
            end else begin
                check($sformatf("%s_idle_x_c%0d", tag, c), a_x, 0);
            end
            if (c >= 2 && c <= 20) check($sformatf("%s_rdy_low_c%0d", tag, c), a_in_ready, 0);
            if (c == 21)           check($sformatf("%s_rdy_back_c%0d", tag, c), a_in_ready, 1);
            if (idx < nw) begin
                in_valid = 1'b1;
                in_data  = words[idx];
                if (a_in_ready) begin
                    acc_cyc[idx] = c;
                    w = words[idx];
                    for (int b = 0; b < W; b++) exp_q.push_back(w[b]);
                    idx++;
                end
            end else begin
                in_valid = 1'b0;
                in_data  = W'($urandom_range(0, 20'hFFFFF));
            end
            tick();
        end
        in_valid = 1'b0;
        check({tag, "_valid_count"}, nvalid, 20 * nw);
        check({tag, "_first_valid"}, first_v, 1);
        check({tag, "_last_valid"},  last_v, 20 * nw);
        check({tag, "_q_drained"},   exp_q.size(), 0);
        check({tag, "_accepted"},    idx, nw);
        check({tag, "_last_pulses"}, nlast, nw);
        for (int k = 0; k < nw; k++) begin
            check($sformatf("%s_acc_cyc%0d", tag, k),  acc_cyc[k],  acc_exp[k]);
            check($sformatf("%s_last_cyc%0d", tag, k), last_cyc[k], 20 * (k + 1));
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int ds;
        int seen;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;

        // Reset held for 4 clk, then the first cycle after release.
        for (int i = 0; i < 4; i++) begin
            tick();
            check_reset_values($sformatf("reset%0d", i));
        end
        reset = 1'b0;
        tick();
        check_reset_values("post_reset");

        // Single word, both bit orders, with the detector chained on the LSB-first stream.
        in_data  = WORD;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = ~WORD;
        ds = 0;
        for (int i = 0; i < 20; i++) begin
            check($sformatf("lsb_x%0d", i),    a_x,       exp_lsb[i]);
            check($sformatf("msb_x%0d", i),    b_x,       exp_msb[i]);
            check($sformatf("lsb_xv%0d", i),   a_x_valid, 1);
            check($sformatf("lsb_last%0d", i), a_x_last,  (i == 19));
            check($sformatf("msb_last%0d", i), b_x_last,  (i == 19));
            ds = moore_next(ds, a_x);
            check($sformatf("det_y%0d", i), (ds == 3), exp_y[i]);
            tick();
        end
        check("single_idle_x",    a_x,       0);
        check("single_idle_xv",   a_x_valid, 0);
        check("single_idle_last", a_x_last,  0);
        check("single_idle_busy", a_busy,    0);
        check("single_idle_msb",  b_x_valid, 0);
        tick();
        tick();

        // Two words back-to-back.
        words[0] = 20'hA5C3F;
        words[1] = 20'h3096E;
        words[2] = 20'h00000;
        run_stream(2, "two");
        tick();
        tick();

        // Three words with in_valid held high; the third stalls until hold drains.
        words[0] = 20'h12345;
        words[1] = 20'hFEDCB;
        words[2] = 20'h80001;
        run_stream(3, "three");
        tick();
        tick();

        // Reset at bit 7 of word 1 with word 2 in hold.
        in_data  = 20'hF0F0F;
        in_valid = 1'b1;
        tick();
        in_data  = 20'h0FFFF;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("midrst_pre_xv",   a_x_valid,  1);
        check("midrst_pre_x",    a_x,        0);
        check("midrst_pre_rdy",  a_in_ready, 0);
        check("midrst_pre_busy", a_busy,     1);
        reset = 1'b1;
        tick();
        check_reset_values("midrst");
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 45; i++) begin
            tick();
            if (a_x_valid || a_x || b_x_valid) seen++;
        end
        check("midrst_no_remnant", seen, 0);
        check("midrst_final_busy", a_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
